// File: rtl/point_buf.sv
// point_buf: first-word-fall-through FIFO of measured {delay, threshold} points with overflow tracking.
module point_buf #(
  parameter int DEPTH_LOG2 = 4,
  parameter int V_WIDTH = 16,
  parameter int T_WIDTH = 10
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       point_rdy_i,
  input  logic [V_WIDTH-1:0]         point_v_i,
  input  logic [T_WIDTH-1:0]         point_t_i,
  input  logic                       clr_i,
  input  logic                       rd_i,
  output logic [T_WIDTH+V_WIDTH-1:0] data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [DEPTH_LOG2:0]        count_o,
  output logic                       ovf_o,
  output logic [7:0]                 drop_cnt_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [T_WIDTH+V_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] count;
  logic ovf;
  logic [7:0] drop_cnt;
  logic push, pop, drop;
  assign valid_o = count != '0;
  assign full_o = count == (DEPTH_LOG2+1)'(DEPTH);
  assign count_o = count;
  assign ovf_o = ovf;
  assign drop_cnt_o = drop_cnt;
  assign data_o = mem[rd_ptr];
  // a pop in the same cycle frees a slot, so a full buffer still accepts the point
  assign pop = rd_i & valid_o;
  assign push = point_rdy_i & (~full_o | pop);
  assign drop = point_rdy_i & full_o & ~pop;
  always_ff @(posedge clk_i)
    if (push && !clr_i) mem[wr_ptr] <= {point_t_i, point_v_i};
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i || clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (push != pop) count <= push ? count + (DEPTH_LOG2+1)'(1) : count - (DEPTH_LOG2+1)'(1);
      if (drop) ovf <= 1'b1;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
endmodule

// File: tb/tb_point_buf.sv
// tb_point_buf: directed checks of point_buf FIFO, overflow, clear and async reset.
module tb_point_buf;
  logic clk = 0, arst = 1, point_rdy = 0, clr = 0, rd = 0;
  logic [15:0] pv = '0;
  logic [9:0] pt = '0;
  logic [25:0] data;
  logic valid, full, ovf;
  logic [4:0] count;
  logic [7:0] drop_cnt;
  int errors = 0, checks = 0;
  logic [25:0] q[$];
  point_buf dut (
    .clk_i(clk), .arst_i(arst), .point_rdy_i(point_rdy), .point_v_i(pv), .point_t_i(pt),
    .clr_i(clr), .rd_i(rd), .data_o(data), .valid_o(valid), .full_o(full),
    .count_o(count), .ovf_o(ovf), .drop_cnt_o(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [15:0] v, input logic [9:0] t);
    point_rdy = 1; pv = v; pt = t;
    tick;
    point_rdy = 0;
  endtask
  task automatic pop;
    rd = 1;
    tick;
    rd = 0;
  endtask
  task automatic zero_state(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask
  initial begin
    tick; tick;
    zero_state("reset");
    arst = 0;
    tick;
    push(16'h1234, 10'h155);
    chk("first_valid", valid, 1);
    chk("first_count", count, 1);
    chk("first_data", data, 26'h1551234);
    pop;
    chk("first_pop_valid", valid, 0);
    chk("first_pop_count", count, 0);
    pop;
    chk("rd_empty_count", count, 0);
    chk("rd_empty_valid", valid, 0);
    // simultaneous write and pop at count 1 shows the new point
    push(16'h0aaa, 10'h001);
    point_rdy = 1; pv = 16'h0bbb; pt = 10'h002; rd = 1;
    tick;
    point_rdy = 0; rd = 0;
    chk("wp1_count", count, 1);
    chk("wp1_valid", valid, 1);
    chk("wp1_data", data, {10'h002, 16'h0bbb});
    pop;
    for (int i = 0; i < 16; i++) push(16'(i), 10'(i + 3));
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovf", ovf, 0);
    for (int i = 0; i < 3; i++) push(16'hdead, 10'h3ff);
    chk("drop3_ovf", ovf, 1);
    chk("drop3_cnt", drop_cnt, 3);
    chk("drop3_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("order_%0d", i), data, {10'(i + 3), 16'(i)});
      pop;
    end
    chk("drained_valid", valid, 0);
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i), 10'h0aa);
    point_rdy = 1; pv = 16'hbeef; pt = 10'h2c3; rd = 1;
    tick;
    point_rdy = 0; rd = 0;
    chk("fullwp_count", count, 16);
    chk("fullwp_drop", drop_cnt, 3);
    chk("fullwp_full", full, 1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("fullwp_order_%0d", i), data, {10'h0aa, 16'h0100 + 16'(i)});
      pop;
    end
    chk("fullwp_last", data, {10'h2c3, 16'hbeef});
    pop;
    chk("fullwp_empty", count, 0);
    for (int i = 0; i < 16; i++) push(16'(i), 10'h0);
    for (int i = 0; i < 300; i++) push(16'hffff, 10'h1);
    chk("sat_drop", drop_cnt, 255);
    chk("sat_ovf", ovf, 1);
    chk("sat_count", count, 16);
    clr = 1; point_rdy = 1; rd = 1;
    tick;
    clr = 0; point_rdy = 0; rd = 0;
    zero_state("clear");
    push(16'h1000, 10'h100);
    q.push_back({10'h100, 16'h1000});
    for (int i = 0; i < 40; i++) begin
      push(16'h2000 + 16'(i), 10'(i * 7));
      q.push_back({10'(i * 7), 16'h2000 + 16'(i)});
      if (count < 1 || count > 3) chk($sformatf("hover_count_%0d", i), count, 2);
      chk($sformatf("wrap_%0d", i), data, q[0]);
      pop;
      void'(q.pop_front());
    end
    chk("wrap_tail", data, q[0]);
    pop;
    chk("wrap_drained", count, 0);
    pop;
    chk("wrap_rd_empty_count", count, 0);
    chk("wrap_rd_empty_valid", valid, 0);
    for (int i = 0; i < 5; i++) push(16'h5000 + 16'(i), 10'h05);
    chk("pre_arst_count", count, 5);
    #2 arst = 1;
    #1;
    zero_state("async");
    #2 arst = 0;
    push(16'h7777, 10'h177);
    chk("post_arst_count", count, 1);
    chk("post_arst_data", data, {10'h177, 16'h7777});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
